// File: rtl/mega65_kb_pkg.sv
// Shared constants and event format for the MEGA65 smart-keyboard link.
package mega65_kb_pkg;

    localparam int KEY_COUNT     = 80;
    localparam int LED_BITS      = 24;
    localparam int EVT_PRESS_BIT = 7;

    // Matrix indices consumed by the software keymap tables
    localparam logic [6:0] KEY_RETURN  = 7'd1;
    localparam logic [6:0] KEY_LSHIFT  = 7'd15;
    localparam logic [6:0] KEY_RSHIFT  = 7'd52;
    localparam logic [6:0] KEY_RUNSTOP = 7'd63;

    typedef struct packed {
        logic       press;
        logic [6:0] key;
    } kb_event_t;

endpackage

// File: rtl/mega65_kb_fifo.sv
// Show-ahead event FIFO; head is forced to zero while empty.
module mega65_kb_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       bus_clk,
    input  logic       bus_reset_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    // Full is judged on the pre-pop count, so push during full+pop is lost
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge bus_clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge bus_clk or negedge bus_reset_n) begin
        if (!bus_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/mega65_keyboard.sv
// MEGA65 keyboard link: slot sequencer, kio10 sampling, key matrix, event FIFO.
// Optional LED transmit in slots 1..24 is enabled by defining MEGA65_KB_LED_EN.
module mega65_keyboard
    import mega65_kb_pkg::*;
#(
    parameter int CLK_DIV    = 7,
    parameter int FRAME_BITS = 128,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 bus_clk,
    input  logic                 bus_reset_n,
    output logic                 io_kio8_o,
    output logic                 io_kio9_o,
    input  logic                 io_kio10_i,
    output logic                 io_event_valid,
    input  logic                 io_event_ready,
    output logic [7:0]           io_event_data,
    output logic [KEY_COUNT-1:0] io_matrix,
    output logic                 io_frame_done
`ifdef MEGA65_KB_LED_EN
    ,
    input  logic [LED_BITS-1:0]  io_leds
`endif
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = $clog2(FRAME_BITS);

    logic [DW-1:0] div;
    logic [SW-1:0] slot, slot_nxt;
    logic          live;
    logic [1:0]    sync;
    logic          div_end, slot_start, kio9_nxt;
    logic          in_keys, pressed, key_changed;
    logic [6:0]    key_idx;
    logic          fifo_full, fifo_empty;
    kb_event_t     evt;

`ifdef MEGA65_KB_LED_EN
    logic [LED_BITS-1:0] led_q;
    logic [4:0]          led_idx;
    assign led_idx = 5'(LED_BITS - int'(slot_nxt));
`endif

    assign div_end    = (div == DW'(CLK_DIV-1));
    // End of a high phase; before the first slot this ends the idle lead-in
    assign slot_start = div_end && io_kio8_o;
    assign slot_nxt   = (!live || slot == SW'(FRAME_BITS-1)) ? '0 : slot + SW'(1);

    always_comb begin
        kio9_nxt = (slot_nxt != '0);
`ifdef MEGA65_KB_LED_EN
        if (slot_nxt >= SW'(1) && slot_nxt <= SW'(LED_BITS))
            kio9_nxt = led_q[led_idx];
`endif
    end

    assign in_keys     = (slot != '0) && (slot <= SW'(KEY_COUNT));
    assign key_idx     = 7'(slot - SW'(1));
    assign pressed     = !sync[1];
    assign key_changed = slot_start && live && in_keys && (pressed != io_matrix[key_idx]);
    assign evt         = '{press: pressed, key: key_idx};

    always_ff @(posedge bus_clk or negedge bus_reset_n) begin
        if (!bus_reset_n) begin
            div           <= '0;
            slot          <= '0;
            live          <= 1'b0;
            sync          <= 2'b11;
            io_kio8_o     <= 1'b1;
            io_kio9_o     <= 1'b1;
            io_frame_done <= 1'b0;
            io_matrix     <= '0;
`ifdef MEGA65_KB_LED_EN
            led_q         <= '0;
`endif
        end else begin
            sync          <= {sync[0], io_kio10_i};
            div           <= div_end ? '0 : div + DW'(1);
            io_frame_done <= slot_start && live && (slot == SW'(FRAME_BITS-1));
            if (div_end) io_kio8_o <= !io_kio8_o;
            if (slot_start) begin
                slot      <= slot_nxt;
                live      <= 1'b1;
                io_kio9_o <= kio9_nxt;
`ifdef MEGA65_KB_LED_EN
                if (slot_nxt == '0) led_q <= io_leds;
`endif
            end
            // A dropped event leaves the matrix bit stale so the next frame retries
            if (key_changed && !fifo_full) io_matrix[key_idx] <= pressed;
        end
    end

    mega65_kb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .bus_clk     (bus_clk),
        .bus_reset_n (bus_reset_n),
        .push        (key_changed),
        .wdata       (evt),
        .pop         (io_event_ready),
        .head        (io_event_data),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    assign io_event_valid = !fifo_empty;

endmodule

// File: tb/tb_mega65_keyboard.sv
// Bench for mega65_keyboard: keyboard model, cycle-accurate reference, directed scenarios.
module tb_mega65_keyboard;
    import mega65_kb_pkg::*;

    localparam int D = 7, F = 128, QD = 8, SLOT = 2*D, FRAME = F*SLOT;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        kio8, kio9, kio10 = 1'b1;
    logic        valid, ready = 1'b1, done;
    logic [7:0]  data;
    logic [79:0] matrix;
    logic [79:0] key_down = '0;
`ifdef MEGA65_KB_LED_EN
    logic [23:0] leds = 24'hFF0080;
`endif

    int tests = 0, fails = 0;
    int cyc;

    always #5 clk = ~clk;

    mega65_keyboard #(.CLK_DIV(D), .FRAME_BITS(F), .FIFO_DEPTH(QD)) dut (
        .bus_clk        (clk),
        .bus_reset_n    (rst_n),
        .io_kio8_o      (kio8),
        .io_kio9_o      (kio9),
        .io_kio10_i     (kio10),
        .io_event_valid (valid),
        .io_event_ready (ready),
        .io_event_data  (data),
        .io_matrix      (matrix),
        .io_frame_done  (done)
`ifdef MEGA65_KB_LED_EN
        ,
        .io_leds        (leds)
`endif
    );

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Edges since reset release; interval c lies between edge c and edge c+1
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Keyboard: locks onto the first start marker, then counts slots on kio8 falls
    int   kb_slot = -1;
    logic kb_p8 = 1'b1;
    always @(posedge clk) begin
        #1;
        if (!rst_n) kb_slot = -1;
        else if (kb_p8 && !kio8) begin
            if (kb_slot < 0) kb_slot = kio9 ? -1 : 0;
            else             kb_slot = (kb_slot + 1) % F;
            kio10 = (kb_slot >= 1 && kb_slot <= 80) ? !key_down[kb_slot-1] : 1'b1;
        end
        kb_p8 = kio8;
    end

    // Reference: slot position from cycle arithmetic, event queue as a plain queue
    int          c = 0;
    logic [7:0]  mq[$];
    logic [7:0]  log_q[$];
    logic [79:0] mm = '0;
    logic [23:0] mled = '0;

    always @(negedge clk) begin : ref_blk
        int u, s, k;
        logic e8, e9, ed, p, can_push, do_pop;
        if (!rst_n) begin
            c = 0; mq.delete(); mm = '0; mled = '0;
        end
        e8 = 1'b1; e9 = 1'b1; ed = 1'b0; u = -1; s = -1;
        if (c >= D) begin
            u  = (c - D) % SLOT;
            s  = ((c - D) / SLOT) % F;
            e8 = (u >= D);
            e9 = (s != 0);
`ifdef MEGA65_KB_LED_EN
            if (s >= 1 && s <= 24) e9 = mled[24-s];
`endif
            ed = (c > D) && ((c - D) % FRAME == 0);
        end
        chk("kio8", 80'(kio8), 80'(e8));
        chk("kio9", 80'(kio9), 80'(e9));
        chk("frame_done", 80'(done), 80'(ed));
        chk("valid", 80'(valid), 80'(mq.size() != 0));
        chk("data", 80'(data), 80'(mq.size() != 0 ? mq[0] : 8'h00));
        chk("matrix", matrix, mm);
        if (rst_n) begin
            if (valid && ready) log_q.push_back(data);
            can_push = (mq.size() < QD);
            do_pop   = ready && (mq.size() != 0);
            if (u == SLOT-1 && s >= 1 && s <= 80) begin
                k = s - 1;
                p = !kio10;
                if (p != mm[k] && can_push) begin
                    mq.push_back({p, 7'(k)});
                    mm[k] = p;
                end
            end
            if (do_pop) void'(mq.pop_front());
`ifdef MEGA65_KB_LED_EN
            if (c + 1 >= D && (c + 1 - D) % FRAME == 0) mled = leds;
`endif
            c++;
        end
    end

    function automatic int st(input int n);
        return D + n*SLOT;
    endfunction

    function automatic int samp(input int n);
        return D + n*SLOT + SLOT - 1;
    endfunction

    task automatic grab(input int fr, output logic [23:0] w);
        for (int n = 1; n <= 24; n++) begin
            wait_cyc(st(fr*F + n) + 3);
            w[24-n] = kio9;
`ifdef MEGA65_KB_LED_EN
            if (fr == 0 && n == 10) leds = 24'h123456;
`endif
        end
    endtask

    int          keys10[10] = '{5, 12, 19, 26, 33, 40, 47, 54, 61, 68};
    logic [7:0]  exp_log[12] = '{8'hA5, 8'h25, 8'h85, 8'h8C, 8'h93, 8'h9A,
                                 8'hA1, 8'hA8, 8'hAF, 8'hB6, 8'hC4, 8'hBD};

    initial begin
        int          falls[4];
        int          nfall, k9low;
        logic        p8;
        logic [79:0] mask8, mask10;
        logic [23:0] w;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle link timing
        nfall = 0; k9low = 0; p8 = 1'b1;
        for (int i = 1; i < FRAME + D - 1; i++) begin
            wait_cyc(i);
            if (p8 && !kio8 && nfall < 4) begin
                falls[nfall] = cyc;
                nfall++;
            end
            p8 = kio8;
            if (!kio9) k9low++;
        end
        for (int i = 0; i < 4; i++) chk("kio8_fall", 80'(falls[i]), 80'(7 + 14*i));
        chk("kio9_low_cycles", 80'(k9low), 80'd14);
        wait_cyc(1799); chk("done_1799", 80'(done), 80'd1);
        wait_cyc(1800); chk("done_1800", 80'(done), 80'd0);
        wait_cyc(3591); chk("done_3591", 80'(done), 80'd1);
        chk("idle_valid", 80'(valid), 80'd0);
        chk("idle_matrix", matrix, 80'd0);

        // Key 37 press from frame 2, then release in frame 4
        key_down[37] = 1'b1;
        wait_cyc(4136); chk("k37_pre_valid", 80'(valid), 80'd0);
        wait_cyc(4137);
        chk("k37_valid", 80'(valid), 80'd1);
        chk("k37_data", 80'(data), 80'hA5);
        chk("k37_matrix", 80'(matrix[37]), 80'd1);
        wait_cyc(4138); chk("k37_popped", 80'(valid), 80'd0);
        wait_cyc(st(4*F));
        chk("k37_held_quiet", 80'(log_q.size()), 80'd1);
        key_down[37] = 1'b0;
        wait_cyc(samp(4*F + 38) + 1);
        chk("k37_rel_data", 80'(data), 80'h25);
        chk("k37_rel_matrix", 80'(matrix[37]), 80'd0);

        // Ten presses with consumer stalled
        wait_cyc(st(5*F));
        ready = 1'b0;
        mask8 = '0; mask10 = '0;
        foreach (keys10[i]) begin
            key_down[keys10[i]] = 1'b1;
            mask10[keys10[i]] = 1'b1;
            if (i < 8) mask8[keys10[i]] = 1'b1;
        end
        wait_cyc(st(6*F));
        chk("full_valid", 80'(valid), 80'd1);
        chk("full_head", 80'(data), 80'h85);
        chk("full_matrix", matrix, mask8);

        // Pop in the very cycle key 61 is sampled against a full queue
        wait_cyc(samp(6*F + 62));
        ready = 1'b1;
        wait_cyc(samp(6*F + 62) + 1);
        ready = 1'b0;
        chk("race_head", 80'(data), 80'h8C);
        chk("race_k61_dropped", 80'(matrix[61]), 80'd0);
        wait_cyc(samp(6*F + 69) + 1);
        chk("k68_arrived", 80'(matrix[68]), 80'd1);

        wait_cyc(st(7*F));
        ready = 1'b1;
        wait_cyc(st(8*F));
        chk("log_size", 80'(log_q.size()), 80'd12);
        for (int i = 0; i < 12; i++)
            chk("log_order", 80'(i < log_q.size() ? log_q[i] : 8'hXX), 80'(exp_log[i]));
        chk("final_matrix", matrix, mask10);

        // Reset in the middle of slot 50
        wait_cyc(st(8*F + 50) + 5);
        rst_n = 1'b0;
        #1;
        chk("rst_kio8", 80'(kio8), 80'd1);
        chk("rst_kio9", 80'(kio9), 80'd1);
        chk("rst_valid", 80'(valid), 80'd0);
        chk("rst_matrix", matrix, 80'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(6);  chk("rst_leadin_hi", 80'(kio8), 80'd1);
        wait_cyc(7);  chk("rst_s0_low", 80'({kio8, kio9}), 80'd0);
        wait_cyc(13); chk("rst_s0_low_end", 80'(kio8), 80'd0);
        wait_cyc(14); chk("rst_s0_high", 80'({kio8, kio9}), 80'b10);

        // LED slots: latched per frame
        grab(0, w);
`ifdef MEGA65_KB_LED_EN
        chk("led_frame0", 80'(w), 80'hFF0080);
`else
        chk("led_frame0", 80'(w), 80'hFFFFFF);
`endif
        grab(1, w);
`ifdef MEGA65_KB_LED_EN
        chk("led_frame1", 80'(w), 80'h123456);
`else
        chk("led_frame1", 80'(w), 80'hFFFFFF);
`endif
        wait_cyc(st(2*F) + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
